pipelined_riscv_uc: RTL and testbench
=====================================

# pipelined_riscv_uc

Pipelined control unit for the five-stage RV64I core: the counterpart that consumes `opcode`/`func3`/`func7`/`zeroE` from the pipelined datapath and drives every control input it expects. It decodes the instruction held in the Decode stage, then carries the control word through its own E/M/W pipeline registers so each signal reaches the datapath in the stage that uses it. It also exports the stage-tagged control bits the hazard unit needs for load-use stall and forwarding decisions.

## Interface
- No parameters.
- `clock` in 1: single clock; all registers rise-edge.
- `reset` in 1: asynchronous, active-low; clears all pipeline registers.
- `opcode` in 7: from the Decode-stage instruction.
- `func3` in 3: from the Decode-stage instruction.
- `func7` in 7: from the Decode-stage instruction.
- `zeroE` in 1: ALU zero flag, Execute stage.
- `FlushE` in 1: from the hazard unit; bubbles the D→E control register.
- `ImmSrcD` out 2: immediate format, combinational from Decode. 00 = I, 01 = S, 10 = B, 11 = J.
- `PCSrcE` out 1: take branch/jump target.
- `ALUSrcE` out 1: 1 = immediate operand.
- `ALUControlE` out 4: ALU operation.
- `MemWriteM` out 1: data-memory write enable.
- `RegWriteW` out 1: register-file write enable.
- `ResultSrcW` out 2: writeback select. 00 = ALU, 01 = memory, 10 = PC+4.
- `ResultSrcE0` out 1: Execute-stage load flag, for the hazard unit.
- `RegWriteM` out 1: for the hazard unit.

## Operation
- **Decoded opcodes:**
  - 0000011 load: RegWrite, ALUSrc, ResultSrc = 01, Imm I, add.
  - 0100011 store: MemWrite, ALUSrc, Imm S, add.
  - 0110011 R-type: RegWrite, ALU op from func3/func7.
  - 0010011 I-ALU: RegWrite, ALUSrc, Imm I, ALU op from func3/func7.
  - 1100011 branch: Branch, Imm B, sub; func3 000 = BEQ, 001 = BNE.
  - 1101111 JAL: RegWrite, Jump, ResultSrc = 10, Imm J.
- **Illegal or unsupported encodings** (any other opcode; branch func3 other than 000/001) decode to an all-zero control word (bubble). `ImmSrcD` = 00 for them. Opcode 0000000 (flushed or reset Decode stage) is therefore a bubble.
- **ALUControl encodings:** add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000.
- **func3 mapping:**
  - 000 → add, except R-type with func7[5] = 1 → sub. I-type ignores func7 for 000.
  - 001 → sll, 010 → slt, 100 → xor, 110 → or, 111 → and.
  - 101 → srl, or sra when func7[5] = 1 (both R- and I-type).
  - 011 → bubble (sltu is not supported).
- **PCSrcE** = JumpE | (BranchE & (zeroE ^ BneE)). It is combinational from E-register bits and `zeroE`.
- **Pipeline registers:**
  - D→E holds RegWrite, ResultSrc, MemWrite, Jump, Branch, Bne, ALUControl, ALUSrc.
  - E→M holds RegWrite, ResultSrc, MemWrite.
  - M→W holds RegWrite, ResultSrc.

## Timing
- A control word decoded with the instruction in D at cycle n is visible:
  - as E outputs in cycle n+1;
  - as `MemWriteM`/`RegWriteM` in n+2;
  - as `RegWriteW`/`ResultSrcW` in n+3.
- `ImmSrcD` has zero latency.
- `FlushE` is synchronous. If high at edge k, the D→E register loads all zeros, so no write, no branch and `ResultSrcE0` = 0 during cycle k+1. The downstream E→M and M→W registers advance normally.
- **Stall:** no stall input. Under `StallD` the datapath holds the D instruction, so the same word is re-decoded. The hazard unit pairs `StallD` with `FlushE`, so no duplicate control word reaches E.
- **Reset:**
  - Asserting `reset` (low) at any time clears every register immediately.
  - Outputs during reset: `PCSrcE`, `ALUSrcE`, `MemWriteM`, `RegWriteM`, `RegWriteW`, `ResultSrcE0` = 0; `ALUControlE` = 0000; `ResultSrcW` = 00.
  - `ImmSrcD` follows the inputs.
  - In-flight instructions are discarded. The first edge after `reset` rises loads normally.
- **Branch with `FlushE` in the same cycle:** the hazard unit asserts `FlushD`/`FlushE` from `PCSrcE`. `PCSrcE` must stay valid for the whole cycle before the flush edge; no registered feedback.

## Structure
- Package `riscv_uc_pkg`:
  - opcode constants;
  - ALUControl encodings;
  - ImmSrc and ResultSrc encodings;
  - packed control-word struct `ctrl_e_t`, sized for the D→E register.
- Sub-module `uc_decoder` (combinational): main decoder plus ALU decoder, producing `ctrl_e_t` and `ImmSrcD`.
- The top module holds the three pipeline registers and the PCSrcE logic.

## Test plan
- **Load:** opcode 0000011 at cycle 0.
  - Cycle 1: `ALUSrcE` = 1, `ALUControlE` = 0000, `ResultSrcE0` = 1.
  - Cycle 2: `RegWriteM` = 1.
  - Cycle 3: `RegWriteW` = 1, `ResultSrcW` = 01.
- **R-type sub and sra:**
  - opcode 0110011, func3 000, func7 0100000 → `ALUControlE` = 0001 next cycle.
  - func3 101, func7 0100000 → 1000.
- **Branches:**
  - BEQ with `zeroE` = 1 → `PCSrcE` = 1.
  - BNE with `zeroE` = 1 → 0; BNE with `zeroE` = 0 → 1.
  - JAL → 1 regardless of `zeroE`, and `ResultSrcW` = 10 three cycles later.
- **Flush:** store in D with `FlushE` = 1 at the edge → `MemWriteM` stays 0 two cycles later. A following instruction without flush proceeds normally.
- **Reset mid-stream:** with a load at M, assert `reset` low asynchronously between edges → all registered outputs go to 0 immediately and no `RegWriteW` pulse follows.
- **Illegal opcode:** 1111111, or opcode 0000000, → no write enables in any stage and `PCSrcE` = 0.

Source files
------------

// File: rtl/riscv_uc_pkg.sv
// riscv_uc_pkg
// Shared encodings for the pipelined RV64I control unit: opcode constants,
// ALU operation codes, immediate/writeback selector codes, the packed
// control word carried through the D->E register, and the ALU decode helper.
package riscv_uc_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1000;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   // Control word held in the D->E pipeline register.
   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic       bne;
      logic [3:0] alu_control;
      logic       alu_src;
   } ctrl_e_t;

   localparam ctrl_e_t CTRL_BUBBLE = '0;

   typedef struct packed {
      logic       valid;
      logic [3:0] op;
   } alu_dec_t;

   // ALU decode from func3/func7[5]; func7[5] selects sub only for R-type,
   // but selects sra for both R- and I-type shifts. func3 011 is unsupported.
   function automatic alu_dec_t alu_decode(input logic [2:0] f3,
                                           input logic       f7_5,
                                           input logic       is_rtype);
      alu_dec_t d;
      d.valid = 1'b1;
      d.op    = ALU_ADD;
      case (f3)
         3'b000:  d.op = (is_rtype && f7_5) ? ALU_SUB : ALU_ADD;
         3'b001:  d.op = ALU_SLL;
         3'b010:  d.op = ALU_SLT;
         3'b011:  d.valid = 1'b0;
         3'b100:  d.op = ALU_XOR;
         3'b101:  d.op = f7_5 ? ALU_SRA : ALU_SRL;
         3'b110:  d.op = ALU_OR;
         default: d.op = ALU_AND;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/pipelined_riscv_uc_decoder.sv
// uc_decoder
// Combinational main decoder plus ALU decoder for the Decode-stage
// instruction. Unsupported encodings produce an all-zero control word and
// ImmSrc 00.
//   opcode, func3, func7 : Decode-stage instruction fields
//   ctrl_d               : control word to be registered into Execute
//   imm_src_d            : immediate format select (zero latency)
module uc_decoder
   import riscv_uc_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   output ctrl_e_t    ctrl_d,
   output logic [1:0] imm_src_d
);

   alu_dec_t alu_dec;
   logic     unused_func7;

   // Only func7[5] carries meaning for the supported instruction set.
   assign unused_func7 = ^{func7[6], func7[4:0]};

   always_comb begin
      ctrl_d    = CTRL_BUBBLE;
      imm_src_d = IMM_I;
      alu_dec   = alu_decode(func3, func7[5], opcode == OP_RTYPE);
      case (opcode)
         OP_LOAD: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.result_src = RES_MEM;
         end
         OP_STORE: begin
            ctrl_d.mem_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            imm_src_d        = IMM_S;
         end
         OP_RTYPE: begin
            if (alu_dec.valid) begin
               ctrl_d.reg_write   = 1'b1;
               ctrl_d.alu_control = alu_dec.op;
            end
         end
         OP_IALU: begin
            if (alu_dec.valid) begin
               ctrl_d.reg_write   = 1'b1;
               ctrl_d.alu_src     = 1'b1;
               ctrl_d.alu_control = alu_dec.op;
            end
         end
         OP_BRANCH: begin
            if (func3 == 3'b000 || func3 == 3'b001) begin
               ctrl_d.branch      = 1'b1;
               ctrl_d.bne         = func3[0];
               ctrl_d.alu_control = ALU_SUB;
               imm_src_d          = IMM_B;
            end
         end
         OP_JAL: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.jump       = 1'b1;
            ctrl_d.result_src = RES_PC4;
            imm_src_d         = IMM_J;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pipelined_riscv_uc.sv
// pipelined_riscv_uc
// Pipelined control unit for the five-stage RV64I core. Decodes the D-stage
// instruction and carries the control word through D->E, E->M and M->W
// registers so each bit arrives in the stage that consumes it.
//   clock, reset (async, active-low)
//   opcode/func3/func7 : Decode-stage instruction fields
//   zeroE              : Execute-stage ALU zero flag
//   FlushE             : bubbles the D->E register at the next edge
//   ImmSrcD            : immediate format (combinational)
//   PCSrcE, ALUSrcE, ALUControlE, ResultSrcE0 : Execute-stage controls
//   MemWriteM, RegWriteM                      : Memory-stage controls
//   RegWriteW, ResultSrcW                     : Writeback-stage controls
module pipelined_riscv_uc
   import riscv_uc_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic       zeroE,
   input  logic       FlushE,
   output logic [1:0] ImmSrcD,
   output logic       PCSrcE,
   output logic       ALUSrcE,
   output logic [3:0] ALUControlE,
   output logic       MemWriteM,
   output logic       RegWriteW,
   output logic [1:0] ResultSrcW,
   output logic       ResultSrcE0,
   output logic       RegWriteM
);

   ctrl_e_t    ctrl_d;
   ctrl_e_t    ctrl_e;
   logic       reg_write_m;
   logic [1:0] result_src_m;
   logic       mem_write_m;
   logic       reg_write_w;
   logic [1:0] result_src_w;

   uc_decoder u_decoder (
      .opcode    (opcode),
      .func3     (func3),
      .func7     (func7),
      .ctrl_d    (ctrl_d),
      .imm_src_d (ImmSrcD)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ctrl_e       <= CTRL_BUBBLE;
         reg_write_m  <= 1'b0;
         result_src_m <= '0;
         mem_write_m  <= 1'b0;
         reg_write_w  <= 1'b0;
         result_src_w <= '0;
      end else begin
         ctrl_e       <= FlushE ? CTRL_BUBBLE : ctrl_d;
         reg_write_m  <= ctrl_e.reg_write;
         result_src_m <= ctrl_e.result_src;
         mem_write_m  <= ctrl_e.mem_write;
         reg_write_w  <= reg_write_m;
         result_src_w <= result_src_m;
      end
   end

   // Purely combinational so it is valid for the whole Execute cycle.
   assign PCSrcE      = ctrl_e.jump | (ctrl_e.branch & (zeroE ^ ctrl_e.bne));
   assign ALUSrcE     = ctrl_e.alu_src;
   assign ALUControlE = ctrl_e.alu_control;
   assign ResultSrcE0 = ctrl_e.result_src[0];
   assign MemWriteM   = mem_write_m;
   assign RegWriteM   = reg_write_m;
   assign RegWriteW   = reg_write_w;
   assign ResultSrcW  = result_src_w;

endmodule

// File: tb/tb_pipelined_riscv_uc.sv
module tb_pipelined_riscv_uc;

   logic       clock = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic [6:0] func7;
   logic       zeroE;
   logic       FlushE;
   logic [1:0] ImmSrcD;
   logic       PCSrcE;
   logic       ALUSrcE;
   logic [3:0] ALUControlE;
   logic       MemWriteM;
   logic       RegWriteW;
   logic [1:0] ResultSrcW;
   logic       ResultSrcE0;
   logic       RegWriteM;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   pipelined_riscv_uc dut (
      .clock       (clock),
      .reset       (reset),
      .opcode      (opcode),
      .func3       (func3),
      .func7       (func7),
      .zeroE       (zeroE),
      .FlushE      (FlushE),
      .ImmSrcD     (ImmSrcD),
      .PCSrcE      (PCSrcE),
      .ALUSrcE     (ALUSrcE),
      .ALUControlE (ALUControlE),
      .MemWriteM   (MemWriteM),
      .RegWriteW   (RegWriteW),
      .ResultSrcW  (ResultSrcW),
      .ResultSrcE0 (ResultSrcE0),
      .RegWriteM   (RegWriteM)
   );

   typedef struct {
      string      name;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       z;
      logic [1:0] imm;
      logic       alu_src;
      logic [3:0] alu;
      logic       pc;
      logic       rs_e0;
      logic       mem_w;
      logic       rw_m;
      logic       rw_w;
      logic [1:0] rs_w;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic z, input logic [1:0] imm,
                      input logic alu_src, input logic [3:0] alu, input logic pc,
                      input logic rs_e0, input logic mem_w, input logic rw_m,
                      input logic rw_w, input logic [1:0] rs_w);
      vec_t v;
      v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z;
      v.imm = imm; v.alu_src = alu_src; v.alu = alu; v.pc = pc; v.rs_e0 = rs_e0;
      v.mem_w = mem_w; v.rw_m = rw_m; v.rw_w = rw_w; v.rs_w = rs_w;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic bubble_inputs();
      opcode = 7'b0000000;
      func3  = 3'b000;
      func7  = 7'b0000000;
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clock);
      opcode = v.op; func3 = v.f3; func7 = v.f7; zeroE = 1'b0;
      #1 check({v.name, ".ImmSrcD"}, {2'b00, ImmSrcD}, {2'b00, v.imm});
      @(posedge clock);
      #1 bubble_inputs();
      zeroE = v.z;
      #1;
      check({v.name, ".ALUSrcE"}, {3'b0, ALUSrcE}, {3'b0, v.alu_src});
      check({v.name, ".ALUControlE"}, ALUControlE, v.alu);
      check({v.name, ".PCSrcE"}, {3'b0, PCSrcE}, {3'b0, v.pc});
      check({v.name, ".ResultSrcE0"}, {3'b0, ResultSrcE0}, {3'b0, v.rs_e0});
      @(posedge clock);
      #1;
      zeroE = 1'b0;
      check({v.name, ".MemWriteM"}, {3'b0, MemWriteM}, {3'b0, v.mem_w});
      check({v.name, ".RegWriteM"}, {3'b0, RegWriteM}, {3'b0, v.rw_m});
      @(posedge clock);
      #1;
      check({v.name, ".RegWriteW"}, {3'b0, RegWriteW}, {3'b0, v.rw_w});
      check({v.name, ".ResultSrcW"}, {2'b00, ResultSrcW}, {2'b00, v.rs_w});
   endtask

   initial begin
      //   name        opcode      f3      f7          z     imm   src  alu    pc   e0   mw   rwM  rwW  rsW
      add("load",     7'b0000011, 3'b010, 7'b0000000, 1'b0, 2'b00, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01);
      add("store",    7'b0100011, 3'b011, 7'b0000000, 1'b0, 2'b01, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      add("r_add",    7'b0110011, 3'b000, 7'b0000000, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
      add("r_sub",    7'b0110011, 3'b000, 7'b0100000, 1'b0, 2'b00, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
      add("r_sra",    7'b0110011, 3'b101, 7'b0100000, 1'b0, 2'b00, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
      add("r_srl",    7'b0110011, 3'b101, 7'b0000000, 1'b0, 2'b00, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
      add("r_and",    7'b0110011, 3'b111, 7'b0000000, 1'b0, 2'b00, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
      add("r_or",     7'b0110011, 3'b110, 7'b0000000, 1'b0, 2'b00, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
      add("r_xor",    7'b0110011, 3'b100, 7'b0000000, 1'b0, 2'b00, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
      add("r_slt",    7'b0110011, 3'b010, 7'b0000000, 1'b0, 2'b00, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
      add("r_sll",    7'b0110011, 3'b001, 7'b0000000, 1'b0, 2'b00, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
      add("r_sltu",   7'b0110011, 3'b011, 7'b0000000, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      add("i_addi",   7'b0010011, 3'b000, 7'b0100000, 1'b0, 2'b00, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
      add("i_srai",   7'b0010011, 3'b101, 7'b0100000, 1'b0, 2'b00, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
      add("i_andi",   7'b0010011, 3'b111, 7'b0000000, 1'b0, 2'b00, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
      add("i_sltiu",  7'b0010011, 3'b011, 7'b0000000, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      add("beq_z1",   7'b1100011, 3'b000, 7'b0000000, 1'b1, 2'b10, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      add("beq_z0",   7'b1100011, 3'b000, 7'b0000000, 1'b0, 2'b10, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      add("bne_z1",   7'b1100011, 3'b001, 7'b0000000, 1'b1, 2'b10, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      add("bne_z0",   7'b1100011, 3'b001, 7'b0000000, 1'b0, 2'b10, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      add("blt_bad",  7'b1100011, 3'b100, 7'b0000000, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      add("jal_z0",   7'b1101111, 3'b000, 7'b0000000, 1'b0, 2'b11, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
      add("jal_z1",   7'b1101111, 3'b101, 7'b0100000, 1'b1, 2'b11, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
      add("op_7f",    7'b1111111, 3'b000, 7'b0000000, 1'b1, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      add("op_00",    7'b0000000, 3'b000, 7'b0000000, 1'b1, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

      reset  = 1'b0;
      FlushE = 1'b0;
      zeroE  = 1'b0;
      bubble_inputs();

      // Reset state
      @(posedge clock);
      @(posedge clock);
      #1;
      check("rst.PCSrcE",      {3'b0, PCSrcE},      4'h0);
      check("rst.ALUSrcE",     {3'b0, ALUSrcE},     4'h0);
      check("rst.ALUControlE", ALUControlE,         4'h0);
      check("rst.MemWriteM",   {3'b0, MemWriteM},   4'h0);
      check("rst.RegWriteM",   {3'b0, RegWriteM},   4'h0);
      check("rst.RegWriteW",   {3'b0, RegWriteW},   4'h0);
      check("rst.ResultSrcW",  {2'b0, ResultSrcW},  4'h0);
      check("rst.ResultSrcE0", {3'b0, ResultSrcE0}, 4'h0);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      // Flush: store flushed at the D->E edge, following load proceeds.
      @(negedge clock);
      opcode = 7'b0100011; func3 = 3'b011; FlushE = 1'b1;
      @(posedge clock);
      #1 FlushE = 1'b0;
      opcode = 7'b0000011; func3 = 3'b011;
      #1;
      check("flush.E_ALUSrcE",     {3'b0, ALUSrcE}, 4'h0);
      @(posedge clock);
      #1 bubble_inputs();
      #1;
      check("flush.MemWriteM",     {3'b0, MemWriteM},   4'h0);
      check("flush.load_E0",       {3'b0, ResultSrcE0}, 4'h1);
      check("flush.load_ALUSrcE",  {3'b0, ALUSrcE},     4'h1);
      @(posedge clock);
      #1;
      check("flush.MemWriteM_next", {3'b0, MemWriteM}, 4'h0);
      check("flush.load_RegWriteM", {3'b0, RegWriteM}, 4'h1);
      @(posedge clock);
      #1;
      check("flush.load_RegWriteW",  {3'b0, RegWriteW},  4'h1);
      check("flush.load_ResultSrcW", {2'b0, ResultSrcW}, 4'h1);

      // Reset mid-stream with a load in M.
      @(negedge clock);
      opcode = 7'b0000011; func3 = 3'b011;
      @(posedge clock);
      #1 bubble_inputs();
      @(posedge clock);
      #1;
      check("midrst.pre_RegWriteM", {3'b0, RegWriteM}, 4'h1);
      #2 reset = 1'b0;
      opcode = 7'b0100011;
      #1;
      check("midrst.RegWriteM",   {3'b0, RegWriteM},   4'h0);
      check("midrst.RegWriteW",   {3'b0, RegWriteW},   4'h0);
      check("midrst.ResultSrcW",  {2'b0, ResultSrcW},  4'h0);
      check("midrst.ResultSrcE0", {3'b0, ResultSrcE0}, 4'h0);
      check("midrst.ImmSrcD",     {2'b0, ImmSrcD},     4'h1);
      @(negedge clock);
      reset = 1'b1;
      bubble_inputs();
      @(posedge clock);
      #1;
      check("midrst.RegWriteW_1", {3'b0, RegWriteW}, 4'h0);
      @(posedge clock);
      #1;
      check("midrst.RegWriteW_2", {3'b0, RegWriteW}, 4'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
